// File: rtl/value_entry_ctrl.sv
// Pushbutton value entry: sync + debounce three buttons, saturating up/down stepping with
// hold-to-auto-repeat, and switch load; bin_out feeds the display driver.
module value_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 10000000,
  parameter int MAX_VAL         = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_load,
  input  logic [11:0] sw_in,
  output logic [11:0] bin_out,
  output logic        changed
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [12:0] MAX13 = 13'(MAX_VAL);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, BLOCKED} state_t;

  // bit 0 = up, bit 1 = down, bit 2 = load
  logic [2:0]    raw;
  logic [2:0]    sync1, sync2;
  logic [2:0]    level, level_q;
  logic [2:0]    armed;
  logic [1:0]    prime;
  logic [DW-1:0] dcnt [3];
  logic [2:0]    rise;

  assign raw = {btn_load, btn_down, btn_up};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prime <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      prime <= {prime[0], 1'b1};
    end
  end

  // A button only produces an edge once it has been seen released after reset, so a
  // button held through reset must be let go and pressed again before it acts.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        dcnt[i]    <= '0;
        level[i]   <= 1'b0;
        level_q[i] <= 1'b0;
        armed[i]   <= 1'b0;
      end else begin
        level_q[i] <= level[i];
        if (sync2[i] == level[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          dcnt[i]  <= '0;
          level[i] <= sync2[i];
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end
        if (prime[1] && !sync2[i] && !level[i]) armed[i] <= 1'b1;
      end
    end
  end

  assign rise = level & ~level_q & armed;

  logic lone_up, lone_dn, active, other;
  assign lone_up = level[0] & ~level[1];
  assign lone_dn = level[1] & ~level[0];

  state_t        state, state_nxt;
  logic          dir, dir_nxt;
  logic [RW-1:0] rcnt, rcnt_nxt, rcnt_inc, limit;
  logic          step, step_up;
  logic [12:0]   bin13, val13, sw13;
  logic          changed_nxt;

  assign active   = dir ? level[0] : level[1];
  assign other    = dir ? level[1] : level[0];
  assign rcnt_inc = rcnt + RW'(1);
  assign limit    = (state == HOLD) ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE);
  assign bin13    = {1'b0, bin_out};
  assign sw13     = {1'b0, sw_in};

  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    rcnt_nxt  = rcnt;
    step      = 1'b0;
    step_up   = dir;
    case (state)
      IDLE: begin
        rcnt_nxt = '0;
        if (rise[0] && rise[1]) begin
          state_nxt = BLOCKED;
        end else if (rise[0] && lone_up) begin
          step      = 1'b1;
          step_up   = 1'b1;
          dir_nxt   = 1'b1;
          state_nxt = HOLD;
        end else if (rise[1] && lone_dn) begin
          step      = 1'b1;
          step_up   = 1'b0;
          dir_nxt   = 1'b0;
          state_nxt = HOLD;
        end
      end
      HOLD, REPEAT: begin
        if (other) begin
          state_nxt = BLOCKED;
          rcnt_nxt  = '0;
        end else if (!active) begin
          state_nxt = IDLE;
          rcnt_nxt  = '0;
        end else if (rcnt_inc == limit) begin
          step      = 1'b1;
          rcnt_nxt  = '0;
          state_nxt = REPEAT;
        end else begin
          rcnt_nxt = rcnt_inc;
        end
      end
      BLOCKED: begin
        rcnt_nxt = '0;
        if (!level[0] && !level[1]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    val13 = bin13;
    if (step) begin
      if (step_up) val13 = (bin13 >= MAX13) ? MAX13 : bin13 + 13'd1;
      else         val13 = (bin13 == 13'd0) ? 13'd0 : bin13 - 13'd1;
    end

    // load beats any step due in the same cycle
    if (rise[2]) begin
      val13     = (sw13 > MAX13) ? MAX13 : sw13;
      state_nxt = IDLE;
      rcnt_nxt  = '0;
    end

    changed_nxt = (val13 != bin13);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      dir     <= 1'b0;
      rcnt    <= '0;
      bin_out <= '0;
      changed <= 1'b0;
    end else begin
      state   <= state_nxt;
      dir     <= dir_nxt;
      rcnt    <= rcnt_nxt;
      bin_out <= val13[11:0];
      changed <= changed_nxt;
    end
  end

endmodule
